// File: rtl/collision_event_scheduler.sv
// Collects per-frame collision flags, merges them into a pending set at start of frame,
// and issues one event per handshake in fixed priority; stops after game over until restart.
module collision_event_scheduler #(
  parameter int NUM_EV = 6,
  parameter int ID_W   = 3,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              restart,
  input  logic              gameover,
  input  logic              collision_bomb_player,
  input  logic              collision_aliens_missile,
  input  logic              collision_ship_missile,
  input  logic              collision_shields_missile,
  input  logic              collision_shields_bomb,
  output logic              event_valid,
  input  logic              event_ready,
  output logic [ID_W-1:0]   event_id,
  output logic [NUM_EV-1:0] pending_mask,
  output logic [DROP_W-1:0] drop_count,
  output logic              game_halted
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam int CNT_W = $clog2(NUM_EV + 1);
  localparam int SUM_W = ((DROP_W > CNT_W) ? DROP_W : CNT_W) + 1;
  localparam logic [SUM_W-1:0] DROP_MAX = (SUM_W'(1) << DROP_W) - SUM_W'(1);

  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_EV-1:0] m);
    lowest_idx = '0;
    for (int i = NUM_EV - 1; i >= 0; i--)
      if (m[i]) lowest_idx = ID_W'(i);
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_EV-1:0] m);
    popcount = '0;
    for (int i = 0; i < NUM_EV; i++)
      popcount = popcount + CNT_W'(m[i]);
  endfunction

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input logic [CNT_W-1:0]  b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    if (sum > DROP_MAX) sat_add = {DROP_W{1'b1}};
    else                sat_add = sum[DROP_W-1:0];
  endfunction

  logic [1:0]        state_q, state_d;
  logic [NUM_EV-1:0] capture_q, capture_d;
  logic [NUM_EV-1:0] pending_q, pending_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [ID_W-1:0]   event_id_q, event_id_d;

  logic [NUM_EV-1:0] ev_in;
  logic [NUM_EV-1:0] ack_mask;
  logic [NUM_EV-1:0] pend_kept;
  logic              handshake;

  assign ev_in = {collision_shields_bomb, collision_shields_missile, collision_ship_missile,
                  collision_aliens_missile, collision_bomb_player, gameover};

  always_comb begin
    handshake  = (state_q == S_ISSUE) && event_ready;
    ack_mask   = handshake ? (NUM_EV'(1) << event_id_q) : '0;
    pend_kept  = pending_q & ~ack_mask;
    state_d    = state_q;
    capture_d  = capture_q;
    pending_d  = pending_q;
    drop_d     = drop_q;
    event_id_d = event_id_q;

    if (restart) begin
      state_d    = S_IDLE;
      capture_d  = '0;
      pending_d  = '0;
      drop_d     = '0;
      event_id_d = '0;
    end else if (state_q == S_HALT) begin
      capture_d = '0;
    end else begin
      // On SOF the finished frame moves to pending; same-cycle hits start the new frame.
      capture_d = startOfFrame ? ev_in : (capture_q | ev_in);
      pending_d = startOfFrame ? (pend_kept | capture_q) : pend_kept;
      if (startOfFrame)
        drop_d = sat_add(drop_q, popcount(pend_kept & capture_q));

      case (state_q)
        S_IDLE: begin
          if (pending_d != '0) begin
            state_d    = S_ISSUE;
            event_id_d = lowest_idx(pending_d);
          end
        end
        S_ISSUE: begin
          if (handshake) begin
            if (event_id_q == '0) begin
              state_d   = S_HALT;
              capture_d = '0;
            end else if (pending_d != '0) begin
              event_id_d = lowest_idx(pending_d);
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      capture_q  <= '0;
      pending_q  <= '0;
      drop_q     <= '0;
      event_id_q <= '0;
    end else begin
      state_q    <= state_d;
      capture_q  <= capture_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      event_id_q <= event_id_d;
    end
  end

  assign event_valid  = (state_q == S_ISSUE);
  assign event_id     = event_id_q;
  assign pending_mask = pending_q;
  assign drop_count   = drop_q;
  assign game_halted  = (state_q == S_HALT);

endmodule
